// File: rtl/mimo_dsp.sv
// mimo_dsp: N-lane cyclic spatial mixer for the MIMO receive path.
// Each output lane is its own sample plus half of the next lane's sample,
// saturated back to DATA_WIDTH. Two registered stages, one vector per cycle.
module mimo_dsp #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*DATA_WIDTH-1:0] data_in,
  output logic [N*DATA_WIDTH-1:0] data_out
);

  localparam int unsigned DW = DATA_WIDTH;
  // One guard bit is enough: |x + x/2| stays below 2^DW.
  localparam int unsigned SW = DATA_WIDTH + 1;

  localparam logic signed [SW-1:0] SAT_MAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {2'b11, {(DW-1){1'b0}}};

  logic [N*DW-1:0] x_q;
  logic [N*DW-1:0] mix_c;

  // Stage 1: capture the raw lane samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
    end else begin
      x_q <= data_in;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    // Cyclic neighbour; a single lane mixes with itself.
    localparam int unsigned J = (i + 1) % N;

    logic signed [SW-1:0] own_c;
    logic signed [SW-1:0] nbr_c;
    logic signed [SW-1:0] sum_c;
    logic        [DW-1:0] sat_c;

    // Widen both samples, add own + (neighbour >>> 1), clip to DW bits.
    always_comb begin
      own_c = {x_q[i*DW+DW-1], x_q[i*DW +: DW]};
      nbr_c = {x_q[J*DW+DW-1], x_q[J*DW +: DW]};
      sum_c = own_c + (nbr_c >>> 1);
      sat_c = sum_c[DW-1:0];
      if (sum_c > SAT_MAX) begin
        sat_c = SAT_MAX[DW-1:0];
      end else if (sum_c < SAT_MIN) begin
        sat_c = SAT_MIN[DW-1:0];
      end
    end

    assign mix_c[i*DW +: DW] = sat_c;
  end

  // Stage 2: register the mixed, saturated lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else begin
      data_out <= mix_c;
    end
  end

endmodule

// File: tb/tb_mimo_dsp.sv
// tb_mimo_dsp: directed vectors with hand-computed mixes for mimo_dsp (N=4, 16-bit).
module tb_mimo_dsp;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] data_in = '0;
  logic [BW-1:0] data_out;

  int checks   = 0;
  int failures = 0;

  mimo_dsp #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (data_out !== '0) begin
      failures++;
      $display("FAIL reset_async: data_out=%h expected=%h", data_out, {BW{1'b0}});
    end
    data_in = 64'h7FFF_1234_8000_0F0F;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (data_out !== '0) begin
      failures++;
      $display("FAIL reset_held_over_edge: data_out=%h expected=%h", data_out, {BW{1'b0}});
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    data_in = 64'h0001_0002_0003_0004;
    @(negedge clk);
    checks++;
    if (data_out !== '0) begin
      failures++;
      $display("FAIL basic_latency_one_edge: data_out=%h expected=%h", data_out, {BW{1'b0}});
    end
    @(negedge clk);
    checks++;
    if (data_out !== 64'h0003_0002_0004_0005) begin
      failures++;
      $display("FAIL basic_mix: data_out=%h expected=%h", data_out, 64'h0003_0002_0004_0005);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] vec [3];
    logic [BW-1:0] exp [3];
    vec[0] = 64'h0010_0020_0030_0040; exp[0] = 64'h0030_0028_0040_0058;
    vec[1] = 64'hFFFF_FFFE_FFFD_FFFC; exp[1] = 64'hFFFD_FFFD_FFFC_FFFA;
    vec[2] = 64'h0001_0002_0003_0004; exp[2] = 64'h0003_0002_0004_0005;
    data_in = vec[0];
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (data_out !== exp[k-2]) begin
          failures++;
          $display("FAIL back_to_back[%0d]: data_out=%h expected=%h", k - 2, data_out, exp[k-2]);
        end
      end
      if (k < 3) data_in = vec[k];
    end
  endtask

  task automatic test_saturation();
    logic [BW-1:0] vec [3];
    logic [BW-1:0] exp [3];
    vec[0] = 64'h0000_0000_7FFF_7FFF; exp[0] = 64'h3FFF_0000_7FFF_7FFF;
    vec[1] = 64'h8000_8000_8000_8000; exp[1] = 64'h8000_8000_8000_8000;
    vec[2] = 64'h8000_7FFF_0000_0001; exp[2] = 64'h8000_3FFF_3FFF_0001;
    data_in = vec[0];
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        checks++;
        if (data_out !== exp[k-2]) begin
          failures++;
          $display("FAIL saturation[%0d]: data_out=%h expected=%h", k - 2, data_out, exp[k-2]);
        end
      end
      if (k < 3) data_in = vec[k];
    end
  endtask

  task automatic test_reset_mid_stream();
    // x0=48AF x1=369C x2=2468 x3=1357:
    // 48AF+1B4E=63FD, 369C+1234=48D0, 2468+09AB=2E13, 1357+2457=37AE
    logic [BW-1:0] new_vec;
    logic [BW-1:0] new_exp;
    new_vec = 64'h1357_2468_369C_48AF;
    new_exp = 64'h37AE_2E13_48D0_63FD;
    data_in = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk);
    #2;
    checks++;
    if (data_out !== 64'h8000_3FFF_3FFF_0001) begin
      failures++;
      $display("FAIL pre_pulse_output: data_out=%h expected=%h", data_out, 64'h8000_3FFF_3FFF_0001);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (data_out !== '0) begin
      failures++;
      $display("FAIL mid_stream_async_clear: data_out=%h expected=%h", data_out, {BW{1'b0}});
    end
    #1 rst = 1'b1;
    @(negedge clk);
    data_in = new_vec;
    @(negedge clk);
    checks++;
    if (data_out !== '0) begin
      failures++;
      $display("FAIL post_reset_discard: data_out=%h expected=%h", data_out, {BW{1'b0}});
    end
    @(negedge clk);
    checks++;
    if (data_out !== new_exp) begin
      failures++;
      $display("FAIL post_reset_mix: data_out=%h expected=%h", data_out, new_exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
